// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the 16-bit datapath.
// master = sequencer side (drives strobes), slave = datapath/memory side.
// Carries opcode, flag/memory status and every datapath strobe.
interface multicycle_control_fsm_if #(
  parameter int CNT_W = 16
);
  // status into the sequencer
  logic [3:0]       Op;
  logic             Perform;
  logic             MemReady;
  // strobes out of the sequencer
  logic             IRWrite;
  logic             PCWrite;
  logic [1:0]       PCSrc;
  logic             MASrc;
  logic             MW;
  logic             LM;
  logic [2:0]       ALUOp;
  logic             SrcB;
  logic             FU;
  logic             RW;
  logic [2:0]       RWSrc;
  logic             Halted;
  logic             Illegal;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    input  Op, Perform, MemReady,
    output IRWrite, PCWrite, PCSrc, MASrc, MW, LM, ALUOp, SrcB, FU, RW, RWSrc,
           Halted, Illegal, InstrCount
  );

  modport slave (
    output Op, Perform, MemReady,
    input  IRWrite, PCWrite, PCSrc, MASrc, MW, LM, ALUOp, SrcB, FU, RW, RWSrc,
           Halted, Illegal, InstrCount
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit: decodes IR opcode and sequences all datapath strobes.
// Latency (MemReady=1): R-type/ADDI 4, LUI 3, LW 5, SW 4, BR 3, JAL 3 cycles.
// Backpressure: MemReady low stalls FETCH, MEM_RD and MEM_WR one cycle per low cycle.
module multicycle_control_fsm #(
  parameter int         CNT_W   = 16,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  multicycle_control_fsm_if.master bus
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LUI  = 4'd5;
  localparam logic [3:0] OP_LW   = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;
  localparam logic [3:0] OP_BR   = 4'd8;
  localparam logic [3:0] OP_JAL  = 4'd9;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [2:0] RWS_ALU   = 3'b000;
  localparam logic [2:0] RWS_MEM   = 3'b001;
  localparam logic [2:0] RWS_UPPER = 3'b010;
  localparam logic [2:0] RWS_PC    = 3'b011;

  localparam logic [1:0] PCS_INC  = 2'b00;
  localparam logic [1:0] PCS_BR   = 2'b01;
  localparam logic [1:0] PCS_JUMP = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB_ALU,
    S_MEM_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_HALT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       op_q;       // opcode captured in DECODE; Op is ignored elsewhere
  logic [CNT_W-1:0] instr_cnt;
  logic             retire;

  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ma_src;
  logic             mem_write;
  logic             load_mem;
  logic [2:0]       alu_op;
  logic             src_b;
  logic             flag_upd;
  logic             reg_write;
  logic [2:0]       reg_src;
  logic             halted;
  logic             illegal;

  // ALU function for the captured opcode; ADDI and anything else adds
  function automatic logic [2:0] alu_of(input logic [3:0] op);
    case (op)
      OP_SUB:  alu_of = ALU_SUB;
      OP_AND:  alu_of = ALU_AND;
      OP_OR:   alu_of = ALU_OR;
      default: alu_of = ALU_ADD;
    endcase
  endfunction

  // state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // capture the opcode once per instruction so later states use a stable value
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_q <= 4'd0;
    end else if (state == S_DECODE) begin
      op_q <= bus.Op;
    end
  end

  // an instruction retires when its last state hands control back to FETCH
  assign retire = (state_nxt == S_FETCH) &&
                  ((state == S_WB_ALU) || (state == S_WB_MEM) || (state == S_MEM_WR) ||
                   (state == S_BRANCH) || (state == S_JUMP));

  // retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      instr_cnt <= '0;
    end else if (retire) begin
      instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  // next-state and Mealy strobe decode; every strobe defaults low
  always_comb begin
    state_nxt = state;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PCS_INC;
    ma_src    = 1'b0;
    mem_write = 1'b0;
    load_mem  = 1'b0;
    alu_op    = ALU_ADD;
    src_b     = 1'b0;
    flag_upd  = 1'b0;
    reg_write = 1'b0;
    reg_src   = RWS_ALU;
    halted    = 1'b0;
    illegal   = 1'b0;

    unique case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
      end

      S_FETCH: begin
        // IR and PC+1 commit together on the cycle memory delivers the word
        ir_write = bus.MemReady;
        pc_write = bus.MemReady;
        if (bus.MemReady) begin
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        if (bus.Op == HALT_OP) begin
          state_nxt = S_HALT;
        end else begin
          case (bus.Op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: state_nxt = S_EXEC;
            OP_LUI:                                 state_nxt = S_WB_ALU;
            OP_LW, OP_SW:                           state_nxt = S_MEM_ADDR;
            OP_BR:                                  state_nxt = S_BRANCH;
            OP_JAL:                                 state_nxt = S_JUMP;
            default: begin
              illegal   = 1'b1;
              state_nxt = S_FETCH;
            end
          endcase
        end
      end

      S_EXEC: begin
        alu_op    = alu_of(op_q);
        src_b     = (op_q == OP_ADDI);
        state_nxt = S_WB_ALU;
      end

      S_WB_ALU: begin
        // ALU controls stay put so the result is stable while it is written
        alu_op    = alu_of(op_q);
        src_b     = (op_q == OP_ADDI);
        reg_write = 1'b1;
        reg_src   = (op_q == OP_LUI) ? RWS_UPPER : RWS_ALU;
        flag_upd  = (op_q != OP_LUI);
        state_nxt = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_op    = ALU_ADD;
        src_b     = 1'b1;
        ma_src    = 1'b1;
        state_nxt = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        ma_src   = 1'b1;
        load_mem = 1'b1;
        if (bus.MemReady) begin
          state_nxt = S_WB_MEM;
        end
      end

      S_WB_MEM: begin
        load_mem  = 1'b1;
        reg_write = 1'b1;
        reg_src   = RWS_MEM;
        state_nxt = S_FETCH;
      end

      S_MEM_WR: begin
        // write is held until memory accepts it
        ma_src    = 1'b1;
        mem_write = 1'b1;
        if (bus.MemReady) begin
          state_nxt = S_FETCH;
        end
      end

      S_BRANCH: begin
        pc_src    = PCS_BR;
        pc_write  = bus.Perform;
        state_nxt = S_FETCH;
      end

      S_JUMP: begin
        // link register receives the already-incremented PC
        reg_write = 1'b1;
        reg_src   = RWS_PC;
        pc_src    = PCS_JUMP;
        pc_write  = 1'b1;
        state_nxt = S_FETCH;
      end

      S_HALT: begin
        halted    = 1'b1;
        state_nxt = S_HALT;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.IRWrite    = ir_write;
  assign bus.PCWrite    = pc_write;
  assign bus.PCSrc      = pc_src;
  assign bus.MASrc      = ma_src;
  assign bus.MW         = mem_write;
  assign bus.LM         = load_mem;
  assign bus.ALUOp      = alu_op;
  assign bus.SrcB       = src_b;
  assign bus.FU         = flag_upd;
  assign bus.RW         = reg_write;
  assign bus.RWSrc      = reg_src;
  assign bus.Halted     = halted;
  assign bus.Illegal    = illegal;
  assign bus.InstrCount = instr_cnt;

endmodule
